// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: data width, opcodes and
// output-stage state encoding.
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_NEGA = 3'd0;
    localparam logic [2:0] OP_NEGB = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

endpackage

// File: rtl/alu4.sv
// Team 4-bit combinational ALU; every operation wraps mod 16.
module alu4
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    // Opcode decode
    always_comb begin
        y = {DATA_W{1'b0}};
        case (op)
            OP_NEGA: y = {DATA_W{1'b0}} - a;
            OP_NEGB: y = {DATA_W{1'b0}} - b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_MUL:  y = a * b;
            OP_XOR:  y = a ^ b;
            default: y = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: on contention the port that was not granted last wins.
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // Grant selection
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the 4-bit ALU with a one-entry result stage.
// Optional res_zero output is enabled by defining ALU_ARB_ZERO_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_a,
    input  logic [3:0]        req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_a,
    input  logic [3:0]        req1_b,
    input  logic [2:0]        req1_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_data,
    output logic              res_id,
`ifdef ALU_ARB_ZERO_EN
    output logic              res_zero,
`endif
    output logic [CNT_W-1:0]  ops_cnt
);

    stage_t             state_r;
    stage_t             state_nxt_s;
    logic               last_r;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [2:0]         op_r;
    logic               id_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         grant_s;
    logic               load_ok_s;
    logic               hs_s;

    assign load_ok_s  = (state_r == ST_EMPTY) | res_ready;
    assign req0_ready = load_ok_s & grant_s[0];
    assign req1_ready = load_ok_s & grant_s[1];
    // Grant implies valid, so a grant while the stage can load is a handshake.
    assign hs_s       = load_ok_s & (grant_s != 2'b00);

    alu_rr_pick u_pick (
        .valid (({req1_valid, req0_valid})),
        .last  (last_r),
        .grant (grant_s)
    );

    alu4 u_alu (
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .y  (res_data)
    );

    // Output stage next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (hs_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (hs_s) begin
                    state_nxt_s = ST_FULL;
                end else if (res_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Output stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture and round-robin pointer update on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {DATA_W{1'b0}};
            b_r    <= {DATA_W{1'b0}};
            op_r   <= 3'd0;
            id_r   <= 1'b0;
            last_r <= 1'b1;
        end else if (hs_s) begin
            a_r    <= grant_s[1] ? req1_a  : req0_a;
            b_r    <= grant_s[1] ? req1_b  : req0_b;
            op_r   <= grant_s[1] ? req1_op : req0_op;
            id_r   <= grant_s[1];
            last_r <= grant_s[1];
        end
    end

    // Completed-result counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (res_valid & res_ready) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign res_valid = (state_r == ST_FULL);
    assign res_id    = id_r;
    assign ops_cnt   = cnt_r;

`ifdef ALU_ARB_ZERO_EN
    assign res_zero  = (res_data == 4'b0000);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             v0, v1, rdy0, rdy1, rr;
    logic [3:0]       a0, b0, a1, b1;
    logic [2:0]       op0, op1;
    logic             res_valid, res_id;
    logic [3:0]       res_data;
    logic [CNT_W-1:0] ops_cnt;
`ifdef ALU_ARB_ZERO_EN
    logic             res_zero;
`endif

    typedef struct {
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   exp_cnt = 0;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_ready (rdy0),
        .req0_a     (a0),
        .req0_b     (b0),
        .req0_op    (op0),
        .req1_valid (v1),
        .req1_ready (rdy1),
        .req1_a     (a1),
        .req1_b     (b1),
        .req1_op    (op1),
        .res_valid  (res_valid),
        .res_ready  (rr),
        .res_data   (res_data),
        .res_id     (res_id),
`ifdef ALU_ARB_ZERO_EN
        .res_zero   (res_zero),
`endif
        .ops_cnt    (ops_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got == expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic push(input logic id, input logic [3:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && res_valid && rr) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("res_data", int'(res_data), int'(e.data));
                check("res_id", int'(res_id), int'(e.id));
                check("ops_cnt_at_take", int'(ops_cnt), exp_cnt);
`ifdef ALU_ARB_ZERO_EN
                check("res_zero", int'(res_zero), int'(e.data == 4'd0));
`endif
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    logic [3:0] ops_exp [8] = '{4'b1010, 4'b1110, 4'b1000, 4'b0100,
                               4'b0010, 4'b0110, 4'b1100, 4'b0100};
    logic [3:0] w_a   [5] = '{4'd1, 4'd3, 4'd7, 4'd2, 4'd9};
    logic [3:0] w_b   [5] = '{4'd2, 4'd3, 4'd1, 4'd3, 4'd4};
    logic [2:0] w_op  [5] = '{OP_ADD, OP_SUB, OP_OR, OP_MUL, OP_AND};
    logic [3:0] w_exp [5] = '{4'd3, 4'd0, 4'd7, 4'd6, 4'd0};
    int         w_cnt [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        {v0, v1} = 2'b00;
        rr = 1'b1;
        a0 = 4'd0; b0 = 4'd0; op0 = 3'd0;
        a1 = 4'd0; b1 = 4'd0; op1 = 3'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_ops_cnt", int'(ops_cnt), 0);
        step();
        rst_n = 1'b1;

        // Single ADD on port 0
        v0 = 1'b1; a0 = 4'd6; b0 = 4'd2; op0 = OP_ADD;
        push(1'b0, 4'd8);
        @(negedge clk);
        check("add_ready0", int'(rdy0), 1);
        check("add_ready1", int'(rdy1), 0);
        step();
        v0 = 1'b0;
        @(negedge clk);
        check("add_latency_valid", int'(res_valid), 1);
        step();
        @(negedge clk);
        check("add_ops_cnt", int'(ops_cnt), 1);
        check("add_empty_after", int'(res_valid), 0);
        step();

        // All opcodes back-to-back on port 1
        a1 = 4'd6; b1 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1; op1 = 3'(i);
            push(1'b1, ops_exp[i]);
            @(negedge clk);
            check("opcov_ready1", int'(rdy1), 1);
            if (i > 0) check("opcov_no_bubble", int'(res_valid), 1);
            step();
        end
        v1 = 1'b0;
        drain();

        // Contention: alternate 0,1,0,1,0,1
        v0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = OP_ADD;
        v1 = 1'b1; a1 = 4'd3; b1 = 4'd1; op1 = OP_ADD;
        for (int k = 0; k < 6; k++) begin
            push(k[0], k[0] ? 4'd4 : 4'd2);
            @(negedge clk);
            check("cont_ready0", int'(rdy0), int'(k[0] == 1'b0));
            check("cont_ready1", int'(rdy1), int'(k[0] == 1'b1));
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        drain();

        // Back-pressure with a pending request on port 1
        v0 = 1'b1; a0 = 4'd6; b0 = 4'd2; op0 = OP_ADD;
        push(1'b0, 4'd8);
        step();
        v0 = 1'b0; rr = 1'b0;
        v1 = 1'b1; a1 = 4'd5; b1 = 4'd3; op1 = OP_AND;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", int'(res_valid), 1);
            check("bp_data", int'(res_data), 8);
            check("bp_ready0", int'(rdy0), 0);
            check("bp_ready1", int'(rdy1), 0);
            check("bp_ops_cnt", int'(ops_cnt), exp_cnt);
            step();
        end
        rr = 1'b1;
        push(1'b1, 4'd1);
        @(negedge clk);
        check("bp_release_ready1", int'(rdy1), 1);
        step();
        v1 = 1'b0;
        drain();

        // Reset while FULL
        rr = 1'b0;
        v0 = 1'b1; a0 = 4'd1; b0 = 4'd1; op0 = OP_ADD;
        step();
        v0 = 1'b0;
        @(negedge clk);
        check("mid_full", int'(res_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_ops_cnt", int'(ops_cnt), 0);
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        rr = 1'b1;
        v0 = 1'b1; a0 = 4'd2; b0 = 4'd5; op0 = OP_XOR;
        v1 = 1'b1; a1 = 4'd4; b1 = 4'd4; op1 = OP_ADD;
        push(1'b0, 4'd7);
        @(negedge clk);
        check("post_rst_ready0", int'(rdy0), 1);
        check("post_rst_ready1", int'(rdy1), 0);
        step();
        v0 = 1'b0;
        push(1'b1, 4'd8);
        @(negedge clk);
        check("post_rst_second", int'(rdy1), 1);
        step();
        v1 = 1'b0;
        drain();

        // Counter wrap (2-bit) and zero results
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                v0 = 1'b1; a0 = w_a[c]; b0 = w_b[c]; op0 = w_op[c];
                push(1'b0, w_exp[c]);
            end else begin
                v0 = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) check("wrap_ops_cnt", int'(ops_cnt), w_cnt[c - 2]);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
